rf_arbiter: RTL and testbench

RF_ARBITER -- requirements
Module: rf_arbiter

---
 rtl/rf_arbiter.sv | 83 ++++++++
 tb/tb_rf_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
// rf_arbiter: two-requester round-robin arbiter in front of a dual-read, single-write register file,
// clearing every rf entry after reset before accepting requests.
module rf_arbiter #(
    parameter int BW = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_we,
    input  logic [1:0][AW-1:0]   req_addr_1,
    input  logic [1:0][AW-1:0]   req_addr_2,
    input  logic [1:0][BW-1:0]   req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic signed [BW-1:0] rsp_data_1,
    output logic signed [BW-1:0] rsp_data_2,
    output logic                 init_done,
    output logic                 rf_rst_n,
    output logic                 rf_chip_en,
    output logic                 rf_write_en_n,
    output logic [AW-1:0]        rf_write_addr,
    output logic [AW-1:0]        rf_read_addr_1,
    output logic [AW-1:0]        rf_read_addr_2,
    output logic signed [BW-1:0] rf_data_in,
    input  logic signed [BW-1:0] rf_data_out_1,
    input  logic signed [BW-1:0] rf_data_out_2
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;
    logic [AW-1:0] cnt, ra1_q, ra2_q;
    logic ptr, sel, grant, rd, rsp_q;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = (state == INIT && cnt == AW'(DEPTH - 1)) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            ptr    <= 1'b0;
            rsp_q  <= 1'b0;
            rsp_id <= 1'b0;
            ra1_q  <= '0;
            ra2_q  <= '0;
        end else begin
            if (state == INIT) cnt <= cnt + 1'b1;
            if (grant) ptr <= ~sel;
            rsp_q <= rd;
            if (rd) begin
                rsp_id <= sel;
                ra1_q  <= req_addr_1[sel];
                ra2_q  <= req_addr_2[sel];
            end
        end
    end

    // every output that could start an rf access is masked while rst is high
    always_comb begin
        sel            = (&req_valid) ? ptr : req_valid[1];
        grant          = !rst && state == RUN && |req_valid;
        rd             = grant && !req_we[sel];
        req_ready      = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
        rf_write_en_n  = !(!rst && (state == INIT || (grant && req_we[sel])));
        rf_write_addr  = (state == INIT) ? cnt : req_addr_1[sel];
        rf_data_in     = (state == INIT) ? '0 : req_wdata[sel];
        rf_read_addr_1 = rd ? req_addr_1[sel] : ra1_q;
        rf_read_addr_2 = rd ? req_addr_2[sel] : ra2_q;
        rsp_valid      = rsp_q && !rst;
        rsp_data_1     = rf_data_out_1;
        rsp_data_2     = rf_data_out_2;
        init_done      = !rst && state == RUN;
        rf_rst_n       = !rst;
        rf_chip_en     = !rst;
    end
endmodule

// File: tb/tb_rf_arbiter.sv
// tb_rf_arbiter: directed bench with a registered-read rf model and a response scoreboard.
module tb_rf_arbiter;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic       id;
        logic [7:0] d1;
        logic [7:0] d2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_we = '0;
    logic [1:0][7:0] req_addr_1 = '0;
    logic [1:0][7:0] req_addr_2 = '0;
    logic [1:0][7:0] req_wdata = '0;
    logic [1:0] req_ready;
    logic rsp_valid, rsp_id, init_done, rf_rst_n, rf_chip_en, rf_write_en_n;
    logic signed [7:0] rsp_data_1, rsp_data_2, rf_data_in;
    logic signed [7:0] rf_data_out_1 = '0;
    logic signed [7:0] rf_data_out_2 = '0;
    logic [7:0] rf_write_addr, rf_read_addr_1, rf_read_addr_2;
    logic [7:0] mem [DEPTH] = '{default: 8'hA5};
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    rf_arbiter #(.BW(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr_1(req_addr_1), .req_addr_2(req_addr_2), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2),
        .init_done(init_done), .rf_rst_n(rf_rst_n), .rf_chip_en(rf_chip_en),
        .rf_write_en_n(rf_write_en_n), .rf_write_addr(rf_write_addr),
        .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
        .rf_data_in(rf_data_in), .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rf_write_en_n) mem[rf_write_addr] <= rf_data_in;
        rf_data_out_1 <= mem[rf_read_addr_1];
        rf_data_out_2 <= mem[rf_read_addr_2];
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d d1=%0h d2=%0h, expected no response", rsp_id, rsp_data_1, rsp_data_2);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data_1 !== e.d1 || rsp_data_2 !== e.d2) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d d1=%0h d2=%0h, expected id=%0d d1=%0h d2=%0h",
                             rsp_id, rsp_data_1, rsp_data_2, e.id, e.d1, e.d2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called just after a rising edge; returns just after the transfer edge
    task automatic req(input int i, input logic we, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] wd, input logic [7:0] e1, input logic [7:0] e2);
        int n = 0;
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr_1[i] = a1;
        req_addr_2[i] = a2;
        req_wdata[i] = wd;
        @(negedge clk);
        while (!req_ready[i] && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("grant_seen", int'(req_ready[i]), 1);
        if (!we) sb.push_back({i[0], e1, e2});
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    initial begin
        int bad, nz;
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_we_n", int'(rf_write_en_n), 1);
        chk("rst_rf_rst_n", int'(rf_rst_n), 0);
        chk("rst_chip_en", int'(rf_chip_en), 0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (init_done || rf_write_en_n || rf_write_addr != i[7:0] || rf_data_in != 0 || req_ready != 0) bad++;
        end
        chk("init_sequence", bad, 0);
        @(negedge clk);
        chk("init_done_rise", int'(init_done), 1);
        chk("chip_en_run", int'(rf_chip_en), 1);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) nz++;
        chk("rf_cleared", nz, 0);
        @(posedge clk);
        #1;
        req(0, 1'b1, 8'h3A, 8'h00, 8'h77, 8'h00, 8'h00);
        req(1, 1'b1, 8'h00, 8'h00, 8'h21, 8'h00, 8'h00);
        req(0, 1'b0, 8'h3A, 8'h00, 8'h00, 8'h77, 8'h21);
        @(negedge clk);
        chk("read_rsp_valid", int'(rsp_valid), 1);
        chk("read_rsp_id", int'(rsp_id), 0);
        @(posedge clk);
        #1;
        req(1, 1'b1, 8'h05, 8'h00, 8'h80, 8'h00, 8'h00);
        req(0, 1'b0, 8'h05, 8'h3A, 8'h00, 8'h80, 8'h77);
        @(negedge clk);
        chk("raw_rsp_valid", int'(rsp_valid), 1);
        chk("raw_signed", int'(rsp_data_1), -128);
        @(posedge clk);
        #1;
        req(1, 1'b0, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00);
        req_we = 2'b00;
        req_addr_1[0] = 8'h3A;
        req_addr_2[0] = 8'h05;
        req_addr_1[1] = 8'h00;
        req_addr_2[1] = 8'h3A;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_grant", int'(req_ready), (k % 2 == 1) ? 2 : 1);
            if (k % 2 == 1) sb.push_back({1'b1, 8'h21, 8'h77});
            else sb.push_back({1'b0, 8'h77, 8'h80});
            @(posedge clk);
        end
        #1 req_valid = 2'b01;
        @(negedge clk);
        chk("pre_rst_grant", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_init_done", int'(init_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        req_we[1] = 1'b0;
        req_addr_1[1] = 8'h3A;
        req_addr_2[1] = 8'h05;
        req_valid = 2'b10;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (req_ready != 0 || init_done || rsp_valid) bad++;
            if (i == 0 && (rf_write_addr != 8'h00 || rf_write_en_n)) bad++;
        end
        chk("reinit_hold", bad, 0);
        @(negedge clk);
        chk("reinit_done", int'(init_done), 1);
        chk("reinit_grant", int'(req_ready), 2);
        sb.push_back({1'b1, 8'h00, 8'h00});
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
